acquisition_sequencer: RTL and testbench
========================================

ACQUISITION_SEQUENCER -- requirements
Module: acquisition_sequencer

Interface
REQ-001 Parameter N_SENS, default 6, number of sensor channels (ADC, encoder, eddy 0-3).
REQ-002 Parameter CNT_W, default 16, width of ratio, timeout and time counters.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pwm_carrier_high  input  1  PWM carrier peak indicator, level.
REQ-006 pwm_carrier_low  input  1  PWM carrier valley indicator, level.
REQ-007 event_sel  input  2  event source: 00 high, 01 low, 10 both, 11 none.
REQ-008 user_ratio  input  CNT_W  number of carrier events per acquisition; 0 treated as 1.
REQ-009 sensor_en  input  N_SENS  per-sensor participation mask.
REQ-010 sensor_done  input  N_SENS  per-sensor done pulse or level.
REQ-011 timeout  input  CNT_W  max WAIT cycles; 0 disables timeout.
REQ-012 sensor_trigger  output  N_SENS  one-cycle start pulse to enabled sensors.
REQ-013 all_done  output  1  one-cycle pulse when acquisition finishes.
REQ-014 sched_isr  output  1  one-cycle pulse, same cycle as all_done.
REQ-015 acq_time  output  N_SENS*CNT_W  per-sensor cycles from trigger to done.
REQ-016 timeout_err  output  N_SENS  sensors missing at timeout, sticky per acquisition.
REQ-017 overrun  output  1  sticky; ratio reached while busy.
REQ-018 busy  output  1  high in TRIG, WAIT, DONE.

Function
REQ-019 Carrier event = rising edge of selected carrier signal(s), detected via one-register delay; both-edges coincident in one cycle count once.
REQ-020 Event counter increments per event in all states; on reaching max(user_ratio,1) it clears and raises ratio_hit for one cycle.
REQ-021 FSM states: IDLE, TRIG, WAIT, DONE.
REQ-022 IDLE -> TRIG on ratio_hit; TRIG samples sensor_en into en_q and drives sensor_trigger = en_q for exactly that cycle.
REQ-023 TRIG -> WAIT next cycle; WAIT timer clears in TRIG, increments each WAIT cycle, saturates at all-ones.
REQ-024 In WAIT, done_q[i] sets on sensor_done[i] & en_q[i]; acq_time[i] captures timer+1 in that cycle; later dones ignored.
REQ-025 WAIT -> DONE when (done_q | sensor_done) covers en_q, or en_q == 0 (one WAIT cycle then DONE).
REQ-026 WAIT -> DONE when timeout != 0 and timer == timeout-1 without completion; timeout_err = en_q & ~done_q; simultaneous final done counts as done.
REQ-027 DONE asserts all_done and sched_isr for one cycle, then -> IDLE.
REQ-028 ratio_hit in TRIG, WAIT or DONE sets overrun and is dropped; no queued acquisition.
REQ-029 timeout_err and acq_time of non-enabled sensors clear in TRIG; overrun clears only on rst.
REQ-030 user_ratio change takes effect at next comparison; count >= new ratio fires ratio_hit on the next event.
REQ-031 event_sel = 11 halts event counting; in-flight acquisition completes normally.

Reset
REQ-032 rst forces IDLE; counters, en_q, done_q, acq_time, timeout_err, overrun = 0; all outputs 0 the cycle after rst.
REQ-033 rst mid-WAIT aborts with no all_done/sched_isr pulse; edge-detect register loads current carrier level to avoid a false event.

Structure
REQ-034 Shared package holds FSM state encoding, event_sel encodings, N_SENS and CNT_W defaults.
REQ-035 One sub-module, carrier_event_counter, owns edge detect, event counting and ratio_hit.

Verification
REQ-036 user_ratio=3, event_sel=00, 9 high edges, en=000001, done 5 cycles after trigger -> 3 triggers, acq_time[0]=5, 3 sched_isr pulses.
REQ-037 en=000011, done0 at 2, done1 at 7, timeout=0 -> all_done 1 cycle after done1, acq_time=2/7.
REQ-038 en=000111, timeout=10, sensor 2 silent -> DONE after WAIT cycle 10, timeout_err=000100.
REQ-039 user_ratio=1, events every 3 cycles, done at 20 -> overrun=1, no second trigger until IDLE.
REQ-040 rst asserted during WAIT -> no pulse, all outputs 0 next cycle, no trigger from stale carrier high.
REQ-041 user_ratio=0, event_sel=10, high and low edges in same cycle -> one event, one trigger.

Source files
------------

// File: rtl/acquisition_sequencer_pkg.sv
// Acquisition sequencer shared types.
// FSM encoding, carrier event selects, default sizes.
package acquisition_sequencer_pkg;

  localparam int N_SENS_DEF = 6;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TRIG = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] EV_HIGH = 2'b00;
  localparam logic [1:0] EV_LOW  = 2'b01;
  localparam logic [1:0] EV_BOTH = 2'b10;
  localparam logic [1:0] EV_NONE = 2'b11;

endpackage

// File: rtl/acquisition_sequencer_if.sv
// Sensor-side bundle of the acquisition sequencer.
// master = sequencer, slave = sensor cluster.
interface acquisition_sequencer_if
  import acquisition_sequencer_pkg::*;
#(
  parameter int N_SENS = N_SENS_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic [N_SENS-1:0]       sensor_en;
  logic [N_SENS-1:0]       sensor_done;
  logic [N_SENS-1:0]       sensor_trigger;
  logic [N_SENS-1:0]       timeout_err;
  logic [N_SENS*CNT_W-1:0] acq_time;

  modport master (
    input  sensor_en,
    input  sensor_done,
    output sensor_trigger,
    output timeout_err,
    output acq_time
  );

  modport slave (
    output sensor_en,
    output sensor_done,
    input  sensor_trigger,
    input  timeout_err,
    input  acq_time
  );

endinterface

// File: rtl/acquisition_sequencer_carrier_event_counter.sv
// Carrier edge detect and ratio divider.
// ratio_hit is a registered one-cycle pulse.
module carrier_event_counter
  import acquisition_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             carrier_high,
  input  logic             carrier_low,
  input  logic [1:0]       event_sel,
  input  logic [CNT_W-1:0] user_ratio,
  output logic             ratio_hit
);

  logic             prev_high;
  logic             prev_low;
  logic             rise_high;
  logic             rise_low;
  logic             ev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] target;
  logic [CNT_W:0]   cnt_inc;

  assign rise_high = carrier_high & ~prev_high;
  assign rise_low  = carrier_low & ~prev_low;

  always_comb begin
    ev = 1'b0;
    unique case (event_sel)
      EV_HIGH: ev = rise_high;
      EV_LOW:  ev = rise_low;
      EV_BOTH: ev = rise_high | rise_low;
      EV_NONE: ev = 1'b0;
    endcase
  end

  assign target  = (user_ratio == '0) ? CNT_W'(1) : user_ratio;
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);

  // Reset loads live levels so a carrier already high is no event.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_high <= carrier_high;
      prev_low  <= carrier_low;
      cnt       <= '0;
      ratio_hit <= 1'b0;
    end else begin
      prev_high <= carrier_high;
      prev_low  <= carrier_low;
      ratio_hit <= 1'b0;
      if (ev) begin
        if (cnt_inc >= {1'b0, target}) begin
          cnt       <= '0;
          ratio_hit <= 1'b1;
        end else begin
          cnt <= cnt_inc[CNT_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/acquisition_sequencer.sv
// Carrier-synchronous sensor acquisition sequencer.
// Triggers sensors, times their done, flags timeouts/overrun.
module acquisition_sequencer
  import acquisition_sequencer_pkg::*;
#(
  parameter int N_SENS = N_SENS_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pwm_carrier_high,
  input  logic                   pwm_carrier_low,
  input  logic [1:0]             event_sel,
  input  logic [CNT_W-1:0]       user_ratio,
  input  logic [CNT_W-1:0]       timeout,
  acquisition_sequencer_if.master sens,
  output logic                   all_done,
  output logic                   sched_isr,
  output logic                   overrun,
  output logic                   busy
);

  state_t                  state;
  logic                    ratio_hit;
  logic [N_SENS-1:0]       en_q;
  logic [N_SENS-1:0]       done_q;
  logic [N_SENS-1:0]       hit;
  logic [N_SENS-1:0]       done_all;
  logic [N_SENS-1:0]       trig_q;
  logic [N_SENS-1:0]       terr_q;
  logic [N_SENS*CNT_W-1:0] acq_q;
  logic [CNT_W-1:0]        timer;
  logic [CNT_W-1:0]        timer_inc;
  logic                    complete;
  logic                    tmo_hit;

  carrier_event_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .carrier_high(pwm_carrier_high),
    .carrier_low (pwm_carrier_low),
    .event_sel   (event_sel),
    .user_ratio  (user_ratio),
    .ratio_hit   (ratio_hit)
  );

  assign hit       = sens.sensor_done & en_q;
  assign done_all  = done_q | hit;
  assign complete  = (done_all & en_q) == en_q;
  assign tmo_hit   = (timeout != '0) &&
                     (timer == timeout - CNT_W'(1));
  assign timer_inc = (&timer) ? timer : timer + CNT_W'(1);

  assign sens.sensor_trigger = trig_q;
  assign sens.timeout_err    = terr_q;
  assign sens.acq_time       = acq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      en_q      <= '0;
      done_q    <= '0;
      trig_q    <= '0;
      terr_q    <= '0;
      acq_q     <= '0;
      timer     <= '0;
      all_done  <= 1'b0;
      sched_isr <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      trig_q    <= '0;
      all_done  <= 1'b0;
      sched_isr <= 1'b0;
      // A hit while busy is lost, never queued.
      if (ratio_hit && state != S_IDLE)
        overrun <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (ratio_hit) begin
            en_q   <= sens.sensor_en;
            trig_q <= sens.sensor_en;
            busy   <= 1'b1;
            state  <= S_TRIG;
          end
        end
        S_TRIG: begin
          timer  <= '0;
          done_q <= '0;
          terr_q <= '0;
          for (int i = 0; i < N_SENS; i++)
            if (!en_q[i])
              acq_q[i*CNT_W +: CNT_W] <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          timer  <= timer_inc;
          done_q <= done_all;
          for (int i = 0; i < N_SENS; i++)
            if (hit[i] && !done_q[i])
              acq_q[i*CNT_W +: CNT_W] <= timer_inc;
          if (complete || tmo_hit) begin
            all_done  <= 1'b1;
            sched_isr <= 1'b1;
            state     <= S_DONE;
            if (!complete)
              terr_q <= en_q & ~done_all;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acquisition_sequencer.sv
// Scoreboard bench for acquisition_sequencer.
// Sensor model answers triggers after per-sensor delays.
module tb_acquisition_sequencer;
  import acquisition_sequencer_pkg::*;

  localparam int NS = 6;
  localparam int CW = 16;

  typedef struct {
    logic [NS-1:0]    en;
    logic [NS*CW-1:0] acq;
    logic [NS-1:0]    terr;
    int               lat;
  } want_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ph;
  logic          pl;
  logic [1:0]    esel;
  logic [CW-1:0] ratio;
  logic [CW-1:0] tmo;
  logic          all_done;
  logic          sched_isr;
  logic          overrun;
  logic          busy;

  want_t            q[$];
  int               checks = 0;
  int               fails = 0;
  int               cyc = 0;
  int               t_trig = 0;
  int               n_trig = 0;
  int               n_isr = 0;
  int               base;
  int               dly[NS];
  int               rem[NS];
  logic [NS*CW-1:0] acq_model;
  logic             busy_d = 1'b0;

  always #5 clk = ~clk;

  acquisition_sequencer_if #(.N_SENS(NS), .CNT_W(CW)) sif ();

  acquisition_sequencer #(
    .N_SENS(NS),
    .CNT_W (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pwm_carrier_high(ph),
    .pwm_carrier_low (pl),
    .event_sel       (esel),
    .user_ratio      (ratio),
    .timeout         (tmo),
    .sens            (sif),
    .all_done        (all_done),
    .sched_isr       (sched_isr),
    .overrun         (overrun),
    .busy            (busy)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] want);
    checks++;
    if (obs !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, want);
    end
  endtask

  task automatic push_exp(input int n);
    want_t w;
    int    maxd;
    bit    all;
    w.en   = sif.sensor_en;
    w.terr = '0;
    maxd   = 0;
    all    = 1'b1;
    for (int i = 0; i < NS; i++) begin
      if (!w.en[i]) begin
        acq_model[i*CW +: CW] = '0;
      end else if (dly[i] != 0 &&
                   (tmo == 0 || dly[i] <= int'(tmo))) begin
        acq_model[i*CW +: CW] = CW'(dly[i]);
        if (dly[i] > maxd) maxd = dly[i];
      end else begin
        all = 1'b0;
        if (tmo != 0) w.terr[i] = 1'b1;
      end
    end
    w.acq = acq_model;
    w.lat = (w.en == '0) ? 2 :
            all ? maxd + 1 : int'(tmo) + 1;
    repeat (n) q.push_back(w);
  endtask

  task automatic ev_pulse(input logic h, input logic l,
                          input int gap);
    @(posedge clk);
    #1 ph = h; pl = l;
    @(posedge clk);
    #1 ph = 1'b0; pl = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic drain(input int lim);
    int k = 0;
    while (q.size() != 0 && k < lim) begin
      @(posedge clk);
      k++;
    end
    chk("drain", q.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic set_cfg(input logic [NS-1:0] en,
                         input int d0, input int d1,
                         input int d2, input int t);
    sif.sensor_en = en;
    foreach (dly[i]) dly[i] = 0;
    dly[0] = d0;
    dly[1] = d1;
    dly[2] = d2;
    tmo = CW'(t);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [NS-1:0] dn;
    want_t         w;
    dn = '0;
    if (rst) begin
      foreach (rem[i]) rem[i] = 0;
      busy_d = 1'b0;
    end else begin
      for (int i = 0; i < NS; i++)
        if (rem[i] > 0) begin
          rem[i]--;
          dn[i] = (rem[i] == 0);
        end
      if (busy && !busy_d) t_trig = cyc;
      if (sif.sensor_trigger != '0) begin
        n_trig++;
        if (q.size() > 0)
          chk("trigger", sif.sensor_trigger, q[0].en);
        else
          chk("trig_unexp", sif.sensor_trigger, 0);
        for (int i = 0; i < NS; i++)
          if (sif.sensor_trigger[i]) rem[i] = dly[i];
      end
      if (sched_isr) n_isr++;
      if (all_done) begin
        chk("isr_with_done", sched_isr, 1);
        if (q.size() > 0) begin
          w = q.pop_front();
          chk("acq_time", sif.acq_time, w.acq);
          chk("timeout_err", sif.timeout_err, w.terr);
          chk("latency", cyc - t_trig, w.lat);
        end else begin
          chk("done_unexp", all_done, 0);
        end
      end
      busy_d = busy;
    end
    sif.sensor_done = dn;
  end

  initial begin
    rst = 1'b1;
    ph = 1'b0;
    pl = 1'b0;
    esel = EV_HIGH;
    ratio = CW'(1);
    acq_model = '0;
    set_cfg('0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", all_done, 0);
    chk("rst_isr", sched_isr, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_trig", sif.sensor_trigger, 0);
    chk("rst_acq", sif.acq_time, 0);
    chk("rst_terr", sif.timeout_err, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // ratio 3, 9 high edges, one sensor done after 5
    ratio = CW'(3);
    set_cfg(6'b000001, 5, 0, 0, 0);
    base = n_trig;
    push_exp(3);
    repeat (9) ev_pulse(1'b1, 1'b0, 2);
    drain(60);
    chk("a_trigs", n_trig - base, 3);
    chk("a_isrs", n_isr, 3);
    chk("a_ovr", overrun, 0);

    // two sensors, no timeout
    ratio = CW'(1);
    set_cfg(6'b000011, 2, 7, 0, 0);
    push_exp(1);
    ev_pulse(1'b1, 1'b0, 2);
    drain(40);

    // sensor 2 silent, timeout 10
    set_cfg(6'b000111, 3, 4, 0, 10);
    push_exp(1);
    ev_pulse(1'b1, 1'b0, 2);
    drain(40);

    // events every 3 cycles while busy
    set_cfg(6'b000001, 20, 0, 0, 0);
    base = n_trig;
    push_exp(1);
    repeat (7) ev_pulse(1'b1, 1'b0, 1);
    drain(60);
    chk("d_trigs", n_trig - base, 1);
    chk("d_ovr", overrun, 1);

    // reset during WAIT with carrier held high
    set_cfg(6'b000001, 0, 0, 0, 0);
    push_exp(1);
    base = n_isr;
    @(posedge clk);
    #1 ph = 1'b1;
    for (int k = 0; k < 20 && !busy; k++) @(posedge clk);
    chk("e_busy", busy, 1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    acq_model = '0;
    @(negedge clk);
    chk("e_busy0", busy, 0);
    chk("e_ovr0", overrun, 0);
    chk("e_done0", all_done, 0);
    chk("e_acq0", sif.acq_time, 0);
    base = n_trig;
    repeat (10) @(posedge clk);
    chk("e_no_trig", n_trig - base, 0);
    #1 ph = 1'b0;
    repeat (3) @(posedge clk);

    // ratio 0, both edges in one cycle
    ratio = '0;
    esel = EV_BOTH;
    set_cfg(6'b000010, 0, 1, 0, 0);
    base = n_trig;
    push_exp(1);
    ev_pulse(1'b1, 1'b1, 4);
    drain(30);
    chk("f_trigs", n_trig - base, 1);

    // counting halted
    ratio = CW'(1);
    esel = EV_NONE;
    base = n_trig;
    repeat (3) ev_pulse(1'b1, 1'b1, 2);
    repeat (5) @(posedge clk);
    chk("g_trigs", n_trig - base, 0);

    // ratio lowered below current count
    esel = EV_HIGH;
    ratio = CW'(5);
    set_cfg(6'b000001, 2, 0, 0, 0);
    base = n_trig;
    repeat (2) ev_pulse(1'b1, 1'b0, 2);
    repeat (3) @(posedge clk);
    chk("h_pre", n_trig - base, 0);
    push_exp(1);
    ratio = CW'(2);
    ev_pulse(1'b1, 1'b0, 2);
    drain(30);
    chk("h_trigs", n_trig - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
